// File: rtl/fwd_sel_ctrl.sv
// EX-stage operand forwarding select and load-use stall controller.
// Tracks EX/MEM destination info; selects are registered at the ID->EX hand-off.
module fwd_sel_ctrl #(
   parameter int REGW = 5,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            hold_in,
   input  logic            flush_in,
   input  logic            id_valid,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic            id_use_rs1,
   input  logic            id_use_rs2,
   input  logic            id_use_imm_b,
   input  logic            id_use_pc_a,
   input  logic [REGW-1:0] id_rd,
   input  logic            id_regwrite,
   input  logic            id_is_load,
   input  logic            id_is_csr,
   output logic [2:0]      ex_sel_a,
   output logic [2:0]      ex_sel_b,
   output logic            stall_id,
   output logic [CNTW-1:0] stall_count
);

   localparam logic [2:0] SEL_RF      = 3'b000;
   localparam logic [2:0] SEL_MEM_ALU = 3'b001;
   localparam logic [2:0] SEL_WB      = 3'b010;
   localparam logic [2:0] SEL_MEM_CSR = 3'b011;
   localparam logic [2:0] SEL_ALT     = 3'b100;

   // The register file is write-first, so the WB stage never needs a forward;
   // only EX and MEM destination info influences the outputs.
   logic            ex_valid, ex_regwrite, ex_is_load, ex_is_csr;
   logic [REGW-1:0] ex_rd;
   logic            mem_valid, mem_regwrite;
   logic [REGW-1:0] mem_rd;

   logic            ex_writer, mem_writer;
   logic [2:0]      sel_a_next, sel_b_next;
   logic            bubble;

   assign ex_writer  = ex_valid  & ex_regwrite  & (ex_rd  != '0);
   assign mem_writer = mem_valid & mem_regwrite & (mem_rd != '0);

   function automatic logic [2:0] op_sel(
      input logic            alt,
      input logic            use_rs,
      input logic [REGW-1:0] rs,
      input logic            exw,
      input logic [REGW-1:0] exrd,
      input logic            excsr,
      input logic            memw,
      input logic [REGW-1:0] memrd
   );
      logic [2:0] s;
      s = SEL_RF;
      if (alt)
         s = SEL_ALT;
      else if (use_rs && exw && (rs == exrd))
         s = excsr ? SEL_MEM_CSR : SEL_MEM_ALU;
      else if (use_rs && memw && (rs == memrd))
         s = SEL_WB;
      return s;
   endfunction

   always_comb begin
      sel_a_next = SEL_RF;
      sel_b_next = SEL_RF;
      if (id_valid) begin
         sel_a_next = op_sel(id_use_pc_a, id_use_rs1, id_rs1, ex_writer, ex_rd,
                             ex_is_csr, mem_writer, mem_rd);
         sel_b_next = op_sel(id_use_imm_b, id_use_rs2, id_rs2, ex_writer, ex_rd,
                             ex_is_csr, mem_writer, mem_rd);
      end
   end

   always_comb begin
      stall_id = id_valid & ~flush_in & ~hold_in & ex_writer & ex_is_load &
                 ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
   end

   assign bubble = flush_in | stall_id;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_valid     <= 1'b0;
         ex_regwrite  <= 1'b0;
         ex_is_load   <= 1'b0;
         ex_is_csr    <= 1'b0;
         ex_rd        <= '0;
         mem_valid    <= 1'b0;
         mem_regwrite <= 1'b0;
         mem_rd       <= '0;
         ex_sel_a     <= SEL_RF;
         ex_sel_b     <= SEL_RF;
         stall_count  <= '0;
      end else if (!hold_in) begin
         mem_valid    <= ex_valid;
         mem_regwrite <= ex_regwrite;
         mem_rd       <= ex_rd;
         if (bubble) begin
            ex_valid <= 1'b0;
            ex_sel_a <= SEL_RF;
            ex_sel_b <= SEL_RF;
         end else begin
            ex_valid    <= id_valid;
            ex_regwrite <= id_regwrite;
            ex_is_load  <= id_is_load;
            ex_is_csr   <= id_is_csr;
            ex_rd       <= id_rd;
            ex_sel_a    <= sel_a_next;
            ex_sel_b    <= sel_b_next;
         end
         // stall_id is already zero whenever flush_in is set
         if (stall_id && (stall_count != {CNTW{1'b1}}))
            stall_count <= stall_count + 1'b1;
      end
   end

endmodule
